// File: rtl/contador_alarma_temp.sv
// Persistence filter for the temperature range comparator: raises cold/heat alarms after a
// run of out-of-range samples, releases them after a run of in-range samples, counts entries.
module contador_alarma_temp #(
  parameter int N_ALARMA  = 4,
  parameter int N_LIBERA  = 2,
  parameter int ANCHO_CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 muestra_valida,
  input  logic                 es_bajo,
  input  logic                 es_alto,
  input  logic                 limpiar,
  output logic                 alarma_frio,
  output logic                 alarma_calor,
  output logic [1:0]           estado,
  output logic [ANCHO_CNT-1:0] cuenta_frio,
  output logic [ANCHO_CNT-1:0] cuenta_calor,
  output logic                 error_entrada
);

  localparam logic [1:0] NORMAL = 2'b00;
  localparam logic [1:0] FRIO   = 2'b01;
  localparam logic [1:0] CALOR  = 2'b10;

  localparam int N_MAX = (N_ALARMA > N_LIBERA) ? N_ALARMA : N_LIBERA;
  localparam int W_R   = (N_MAX > 1) ? $clog2(N_MAX + 1) : 1;

  localparam logic [W_R-1:0] UMBRAL_ALARMA = W_R'(N_ALARMA);
  localparam logic [W_R-1:0] UMBRAL_LIBERA = W_R'(N_LIBERA);

  function automatic logic [ANCHO_CNT-1:0] incr_sat(input logic [ANCHO_CNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [W_R-1:0] racha_frio, racha_calor, racha_lib;
  logic [W_R-1:0] racha_frio_sig, racha_calor_sig, racha_lib_sig;
  logic [W_R-1:0] frio_mas, calor_mas, lib_mas;
  logic [1:0]     estado_sig;
  logic           inc_frio, inc_calor;
  logic           m_bajo, m_alto, m_doble;

  // Double-flag samples fall into neither class, so they behave as NEUTRO.
  assign m_bajo  = muestra_valida & es_bajo & ~es_alto;
  assign m_alto  = muestra_valida & es_alto & ~es_bajo;
  assign m_doble = muestra_valida & es_bajo & es_alto;

  assign frio_mas  = racha_frio + 1'b1;
  assign calor_mas = racha_calor + 1'b1;
  assign lib_mas   = racha_lib + 1'b1;

  always_comb begin
    estado_sig      = estado;
    racha_frio_sig  = racha_frio;
    racha_calor_sig = racha_calor;
    racha_lib_sig   = racha_lib;
    inc_frio        = 1'b0;
    inc_calor       = 1'b0;
    case (estado)
      NORMAL: begin
        if (m_bajo) begin
          racha_calor_sig = '0;
          if (frio_mas == UMBRAL_ALARMA) begin
            estado_sig     = FRIO;
            inc_frio       = 1'b1;
            racha_frio_sig = '0;
            racha_lib_sig  = '0;
          end else begin
            racha_frio_sig = frio_mas;
          end
        end else if (m_alto) begin
          racha_frio_sig = '0;
          if (calor_mas == UMBRAL_ALARMA) begin
            estado_sig      = CALOR;
            inc_calor       = 1'b1;
            racha_calor_sig = '0;
            racha_lib_sig   = '0;
          end else begin
            racha_calor_sig = calor_mas;
          end
        end else if (muestra_valida) begin
          racha_frio_sig  = '0;
          racha_calor_sig = '0;
        end
      end
      FRIO: begin
        if (m_bajo) begin
          racha_lib_sig = '0;
        end else if (muestra_valida) begin
          if (lib_mas == UMBRAL_LIBERA) begin
            estado_sig    = NORMAL;
            racha_lib_sig = '0;
          end else begin
            racha_lib_sig = lib_mas;
          end
        end
      end
      CALOR: begin
        if (m_alto) begin
          racha_lib_sig = '0;
        end else if (muestra_valida) begin
          if (lib_mas == UMBRAL_LIBERA) begin
            estado_sig    = NORMAL;
            racha_lib_sig = '0;
          end else begin
            racha_lib_sig = lib_mas;
          end
        end
      end
      default: begin
        estado_sig      = NORMAL;
        racha_frio_sig  = '0;
        racha_calor_sig = '0;
        racha_lib_sig   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= NORMAL;
      racha_frio   <= '0;
      racha_calor  <= '0;
      racha_lib    <= '0;
      alarma_frio  <= 1'b0;
      alarma_calor <= 1'b0;
    end else begin
      estado       <= estado_sig;
      racha_frio   <= racha_frio_sig;
      racha_calor  <= racha_calor_sig;
      racha_lib    <= racha_lib_sig;
      alarma_frio  <= (estado_sig == FRIO);
      alarma_calor <= (estado_sig == CALOR);
    end
  end

  // Clear beats a coincident increment; a fresh double-flag error beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_frio   <= '0;
      cuenta_calor  <= '0;
      error_entrada <= 1'b0;
    end else begin
      if (limpiar)        cuenta_frio <= '0;
      else if (inc_frio)  cuenta_frio <= incr_sat(cuenta_frio);
      if (limpiar)        cuenta_calor <= '0;
      else if (inc_calor) cuenta_calor <= incr_sat(cuenta_calor);
      if (m_doble)        error_entrada <= 1'b1;
      else if (limpiar)   error_entrada <= 1'b0;
    end
  end

endmodule
